// File: rtl/ifetch_pkg.sv
// rtl/ifetch_pkg.sv - shared types, constants and helpers for the instruction fetch stage
package ifetch_pkg;

    localparam int INSTR_W = 12;

    typedef logic [INSTR_W-1:0] instr_t;

    localparam logic [3:0] OPC_HALT = 4'hF;

    function automatic logic [3:0] opcode(input instr_t instr);
        return instr[INSTR_W-1 -: 4];
    endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// rtl/ifetch_fifo.sv - prefetch queue holding {pc, instruction} entries
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   push, push_data   write an entry at the tail
//   pop               remove the head entry (ignored while empty)
//   flush             drop all entries; takes priority over push and pop
//   count             number of stored entries
//   head              head entry, zero while empty
//   not_empty         queue holds at least one entry
module ifetch_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 20,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output logic [W-1:0]     head,
    output logic             not_empty
);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign not_empty = (count != '0);
    assign do_pop    = pop && not_empty;
    // The caller's credit scheme prevents overflow; a pop in the same
    // cycle frees a slot, so a full-queue push is still accepted then.
    assign do_push   = push && ((count != CNT_W'(DEPTH)) || do_pop);

    // Zero while empty so the bus reads 0 after reset and after a flush.
    assign head = not_empty ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; entries are only visible through count.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - sequential instruction fetch with prefetch queue and redirect
//
// Optional feature macro: IFETCH_HALT_EN (stop fetching after a HALT word).
//
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   imem_req, imem_addr              read strobe and address to instruction memory
//   imem_rdata                       read data, one cycle after imem_req
//   instruction_bus, instr_pc        head instruction and its PC
//   instr_valid, instr_ready         handshake to the core
//   redirect_valid, redirect_pc      flush and restart fetch at a new PC
//   halted                           fetch stopped on HALT (0 without IFETCH_HALT_EN)
module instr_fetch
    import ifetch_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instruction_bus,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              halted
);

    localparam int ENTRY_W = ADDR_W + INSTR_W;
    localparam int CNT_W   = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  resp_pc;
    logic               inflight;
    logic [CNT_W-1:0]   count;
    logic [ENTRY_W-1:0] head;
    logic               not_empty;
    logic               credit_ok;
    logic               kill;
    logic               push;
    logic               pop;
    logic               halted_q;

    // Credit counts the registered queue occupancy plus the outstanding
    // read, so a same-cycle pop never frees a slot for a new request.
    assign credit_ok = ({1'b0, count} + {{CNT_W{1'b0}}, inflight}) < (CNT_W+1)'(DEPTH);

    assign imem_req  = !rst && !redirect_valid && !halted_q && credit_ok;
    assign imem_addr = pc;

    // A response landing in a redirect cycle, or after a HALT word was
    // queued, belongs to a stream the core no longer wants.
    assign kill = redirect_valid || halted_q;
    assign push = inflight && !kill;
    assign pop  = instr_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= RESET_PC;
            resp_pc  <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                resp_pc <= pc;
            end
            if (redirect_valid) begin
                pc <= redirect_pc;
            end else if (imem_req) begin
                pc <= pc + ADDR_W'(1);
            end
        end
    end

`ifdef IFETCH_HALT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halted_q <= 1'b0;
        end else if (redirect_valid) begin
            halted_q <= 1'b0;
        end else if (push && (opcode(imem_rdata) == OPC_HALT)) begin
            halted_q <= 1'b1;
        end
    end
`else
    assign halted_q = 1'b0;
`endif

    assign halted = halted_q;

    ifetch_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({resp_pc, imem_rdata}),
        .pop       (pop),
        .flush     (redirect_valid),
        .count     (count),
        .head      (head),
        .not_empty (not_empty)
    );

    assign instr_valid     = not_empty;
    assign instruction_bus = head[INSTR_W-1:0];
    assign instr_pc        = head[ENTRY_W-1 -: ADDR_W];

endmodule
